isp_demosaic_ed: RTL and testbench

//  Parametrised 3x3 demosaic for the ISP RAW->RGB path. Successor to the fixed bilinear

---
 rtl/isp_demosaic_ed.sv | 218 +++++++++++++++++++++
 tb/tb_isp_demosaic_ed.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_demosaic_ed.sv
// 3x3 Bayer demosaic (bilinear / edge-directed green / gray bypass), mirrored top/left borders.
// Latency 3 pclk on sync and data; no backpressure, one pixel accepted every href cycle.
module isp_demosaic_ed #(
    parameter int BITS     = 10,
    parameter int OUT_BITS = 8,
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 960
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic                in_de,
    input  logic [BITS-1:0]     in_raw,
    input  logic [1:0]          cfg_bayer,
    input  logic [1:0]          cfg_mode,
    output logic                out_href,
    output logic                out_vsync,
    output logic                out_de,
    output logic [OUT_BITS-1:0] out_r,
    output logic [OUT_BITS-1:0] out_g,
    output logic [OUT_BITS-1:0] out_b
);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(HEIGHT + 1);
    localparam int SW = BITS + 2;

    logic [CW-1:0]   col;
    logic [LW-1:0]   line;
    logic            href0, vsync0, de0;
    logic [1:0]      bayer_q, mode_q;

    logic [BITS-1:0] lb0 [WIDTH];
    logic [BITS-1:0] lb1 [WIDTH];
    logic [AW-1:0]   addr;
    logic            in_range;
    logic [BITS-1:0] rd0, rd1;

    logic [BITS-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [CW-1:0]   w_col;
    logic [LW-1:0]   w_line;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            line    <= '0;
            href0   <= 1'b0;
            vsync0  <= 1'b0;
            de0     <= 1'b0;
            bayer_q <= '0;
            mode_q  <= '0;
        end else begin
            href0  <= in_href;
            vsync0 <= in_vsync;
            de0    <= in_de;
            if (in_vsync && !vsync0) begin
                bayer_q <= cfg_bayer;
                mode_q  <= cfg_mode;
            end
            col <= in_href ? col + CW'(1) : '0;
            if (in_vsync)
                line <= '0;
            else if (href0 && !in_href)
                line <= line + LW'(1);
        end
    end

    // lb0 holds the previous raw line, lb1 the one before; read-before-write per column
    always_comb begin
        addr     = col[AW-1:0];
        in_range = (col < CW'(WIDTH));
        rd0      = in_range ? lb0[addr] : '0;
        rd1      = in_range ? lb1[addr] : '0;
    end

    always_ff @(posedge pclk) begin
        if (in_href && in_range) begin
            lb1[addr] <= rd0;
            lb0[addr] <= in_raw;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
            w_col  <= '0;
            w_line <= '0;
        end else if (in_href) begin
            p11 <= p12; p12 <= p13; p13 <= rd1;
            p21 <= p22; p22 <= p23; p23 <= rd0;
            p31 <= p32; p32 <= p33; p33 <= in_raw;
            w_col  <= col;
            w_line <= line;
        end
    end

    // Window centre sits one row up and one column left of the newest sample
    logic            mir_c, mir_r;
    logic [BITS-1:0] t1, t2, t3, l1, l2, l3;

    always_comb begin
        mir_c = (w_col == CW'(1));
        mir_r = (w_line == LW'(1));
        t1 = mir_r ? p31 : p11;
        t2 = mir_r ? p32 : p12;
        t3 = mir_r ? p33 : p13;
        l1 = mir_c ? t3  : t1;
        l2 = mir_c ? p23 : p21;
        l3 = mir_c ? p33 : p31;
    end

    logic [SW-1:0]   s_h, s_v, s_x, s_c;
    logic [BITS-1:0] d_h, d_v, c22;
    logic [1:0]      phase_s1, mode_s1;
    logic            blank_s1, href1, vsync1, de1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s_h <= '0; s_v <= '0; s_x <= '0; s_c <= '0;
            d_h <= '0; d_v <= '0; c22 <= '0;
            phase_s1 <= '0;
            mode_s1  <= '0;
            blank_s1 <= 1'b0;
            href1    <= 1'b0;
            vsync1   <= 1'b0;
            de1      <= 1'b0;
        end else begin
            s_h <= SW'(l2) + SW'(p23);
            s_v <= SW'(t2) + SW'(p32);
            s_x <= SW'(l1) + SW'(t3) + SW'(l3) + SW'(p33);
            s_c <= SW'(l2) + SW'(p23) + SW'(t2) + SW'(p32);
            d_h <= (l2 > p23) ? l2 - p23 : p23 - l2;
            d_v <= (t2 > p32) ? t2 - p32 : p32 - t2;
            c22 <= p22;
            phase_s1 <= bayer_q ^ {~w_line[0], ~w_col[0]};
            mode_s1  <= mode_q;
            blank_s1 <= (w_line == '0) || (w_col == '0);
            href1    <= href0;
            vsync1   <= vsync0;
            de1      <= de0;
        end
    end

    logic [BITS-1:0] a_h, a_v, a_x, a_c, g_rb, r_v, g_v, b_v;

    always_comb begin
        a_h  = BITS'((s_h + SW'(1)) >> 1);
        a_v  = BITS'((s_v + SW'(1)) >> 1);
        a_x  = BITS'((s_x + SW'(2)) >> 2);
        a_c  = BITS'((s_c + SW'(2)) >> 2);
        g_rb = a_c;
        if (mode_s1 == 2'd1) begin
            if (d_h < d_v)
                g_rb = a_h;
            else if (d_v < d_h)
                g_rb = a_v;
        end
        // phase 0 R site, 1 G on R row, 2 G on B row, 3 B site
        case (phase_s1)
            2'd0:    begin r_v = c22; g_v = g_rb; b_v = a_x; end
            2'd1:    begin r_v = a_h; g_v = c22;  b_v = a_v; end
            2'd2:    begin r_v = a_v; g_v = c22;  b_v = a_h; end
            default: begin r_v = a_x; g_v = g_rb; b_v = c22; end
        endcase
        if (mode_s1 == 2'd2) begin
            r_v = c22;
            g_v = c22;
            b_v = c22;
        end
    end

    logic [OUT_BITS-1:0] r_o, g_o, b_o;

    if (OUT_BITS == BITS) begin : g_same
        always_comb begin
            r_o = r_v;
            g_o = g_v;
            b_o = b_v;
        end
    end else begin : g_scale
        localparam int D = BITS - OUT_BITS;
        function automatic logic [OUT_BITS-1:0] scale(input logic [BITS-1:0] v);
            logic [OUT_BITS:0] t;
            t = {1'b0, v[BITS-1:D]} + {{OUT_BITS{1'b0}}, v[D-1]};
            return t[OUT_BITS] ? '1 : t[OUT_BITS-1:0];
        endfunction
        always_comb begin
            r_o = scale(r_v);
            g_o = scale(g_v);
            b_o = scale(b_v);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else begin
            out_href  <= href1;
            out_vsync <= vsync1;
            out_de    <= de1;
            if (href1 && !blank_s1) begin
                out_r <= r_o;
                out_g <= g_o;
                out_b <= b_o;
            end else begin
                out_r <= '0;
                out_g <= '0;
                out_b <= '0;
            end
        end
    end
endmodule

// File: tb/tb_isp_demosaic_ed.sv
// Randomised frame bench for isp_demosaic_ed against a neighbour-averaging colour model.
module tb_isp_demosaic_ed;
    localparam int BITS = 10;
    localparam int OB   = 8;
    localparam int W    = 16;
    localparam int H    = 8;

    logic            pclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_href = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic [BITS-1:0] in_raw = '0;
    logic [1:0]      cfg_bayer = '0, cfg_mode = '0;
    logic            out_href, out_vsync, out_de;
    logic [OB-1:0]   out_r, out_g, out_b;

    isp_demosaic_ed #(.BITS(BITS), .OUT_BITS(OB), .WIDTH(W), .HEIGHT(H)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .in_href(in_href), .in_vsync(in_vsync), .in_de(in_de), .in_raw(in_raw),
        .cfg_bayer(cfg_bayer), .cfg_mode(cfg_mode),
        .out_href(out_href), .out_vsync(out_vsync), .out_de(out_de),
        .out_r(out_r), .out_g(out_g), .out_b(out_b)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct packed {
        logic          h;
        logic          v;
        logic          d;
        logic [OB-1:0] r;
        logic [OB-1:0] g;
        logic [OB-1:0] b;
    } exp_t;

    exp_t            ring [16];
    logic [BITS-1:0] fr [H][W];
    int              checks = 0, errors = 0;
    int              m_bayer = 0, m_mode = 0;
    logic            prev_v = 1'b0;
    int              lat_arm = 0, lat_in = -1, lat_out = -1;

    function automatic void cmp(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, want);
        end
    endfunction

    // Colour channel of a raw site: 0 red, 1 green, 2 blue
    function automatic int color_of(input int y, input int x, input int bay);
        int ph;
        ph = bay ^ (((y & 1) << 1) | (x & 1));
        return (ph == 0) ? 0 : (ph == 3) ? 2 : 1;
    endfunction

    function automatic int px(input int y, input int x);
        if (y < 0) y = -y;
        if (x < 0) x = -x;
        return int'(fr[y][x]);
    endfunction

    function automatic int scale8(input int v);
        int s;
        s = (v >> 2) + ((v >> 1) & 1);
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int chan(input int cy, input int cx, input int c, input int bay, input int md);
        int sum, n, dh, dv, l, r, u, d;
        sum = 0;
        n = 0;
        if (md == 2 || color_of(cy, cx, bay) == c) return px(cy, cx);
        l = px(cy, cx - 1); r = px(cy, cx + 1);
        u = px(cy - 1, cx); d = px(cy + 1, cx);
        if (c == 1 && md == 1) begin
            dh = (l > r) ? l - r : r - l;
            dv = (u > d) ? u - d : d - u;
            if (dh < dv) return (l + r + 1) / 2;
            if (dv < dh) return (u + d + 1) / 2;
        end
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (!(dy == 0 && dx == 0) && color_of(cy + dy, cx + dx, bay) == c) begin
                    sum += px(cy + dy, cx + dx);
                    n++;
                end
        return (sum + n / 2) / n;
    endfunction

    function automatic int exp_pix(input int L, input int X, input int c, input int bay, input int md);
        if (L == 0 || X == 0) return 0;
        return scale8(chan(L - 1, X - 1, c, bay, md));
    endfunction

    task automatic step(input logic h, input logic v, input int L, input int X);
        exp_t e;
        in_href  = h;
        in_vsync = v;
        in_de    = h;
        in_raw   = h ? fr[L][X] : '0;
        if (v && !prev_v && rst_n) begin
            m_bayer = int'(cfg_bayer);
            m_mode  = int'(cfg_mode);
        end
        prev_v = v;
        if (lat_arm != 0 && h && rst_n && lat_in < 0) lat_in = cyc;
        e = '0;
        if (rst_n) begin
            e.h = h;
            e.v = v;
            e.d = h;
            if (h) begin
                e.r = OB'(exp_pix(L, X, 0, m_bayer, m_mode));
                e.g = OB'(exp_pix(L, X, 1, m_bayer, m_mode));
                e.b = OB'(exp_pix(L, X, 2, m_bayer, m_mode));
            end
        end
        ring[cyc % 16] = e;
        @(posedge pclk);
        #1;
    endtask

    task automatic run_frame(input int bayer, input int mode, input int chg_line, input int rst_line);
        logic aborted;
        aborted   = 1'b0;
        cfg_bayer = 2'(bayer);
        cfg_mode  = 2'(mode);
        step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == chg_line && x == 3) begin
                    cfg_mode  = 2'(mode ^ 1);
                    cfg_bayer = 2'(bayer ^ 3);
                end
                if (y == rst_line && x == 5) begin
                    rst_n = 1'b0;
                    #1;
                    cmp("rst_href", int'(out_href), 0);
                    cmp("rst_de", int'(out_de), 0);
                    cmp("rst_rgb", int'({out_r, out_g, out_b}), 0);
                end
                if (y == rst_line && x == 10) begin
                    rst_n   = 1'b1;
                    aborted = 1'b1;
                end
                if (aborted) step(0, 0, 0, 0);
                else         step(1, 0, y, x);
            end
            repeat (4) step(0, 0, 0, 0);
        end
    endtask

    task automatic fill_flat(input int v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = BITS'(v);
    endtask

    // Raw laid out as RGGB regardless of the configured phase
    task automatic fill_rgb(input int r, input int g, input int b);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = BITS'(((y % 2) == 0 && (x % 2) == 0) ? r :
                                 ((y % 2) == 1 && (x % 2) == 1) ? b : g);
    endtask

    task automatic fill_rand();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = BITS'($urandom_range(0, 1023));
    endtask

    always @(negedge pclk) begin
        exp_t e;
        if (cyc >= 3) begin
            e = rst_n ? ring[(cyc - 3) % 16] : '0;
            cmp("out_href", int'(out_href), int'(e.h));
            cmp("out_vsync", int'(out_vsync), int'(e.v));
            cmp("out_de", int'(out_de), int'(e.d));
            cmp("out_r", int'(out_r), int'(e.r));
            cmp("out_g", int'(out_g), int'(e.g));
            cmp("out_b", int'(out_b), int'(e.b));
        end
        if (lat_arm != 0 && out_href && lat_out < 0) lat_out = cyc;
    end

    initial begin
        for (int i = 0; i < 16; i++) ring[i] = '0;
        @(posedge pclk);
        #1;
        repeat (4) step(0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) step(0, 0, 0, 0);

        cmp("pin_scale_sat", scale8(1023), 255);
        cmp("pin_scale_round", scale8(514), 129);
        fill_flat(512);
        cmp("pin_flat", exp_pix(3, 5, 1, 2, 1), 128);
        for (int m = 0; m < 4; m++)
            for (int b = 0; b < 4; b++)
                run_frame(b, m, -1, -1);

        fill_rgb(1000, 400, 100);
        cmp("pin_rggb_r", exp_pix(2, 2, 0, 0, 0), 250);
        cmp("pin_rggb_g", exp_pix(2, 2, 1, 0, 0), 100);
        cmp("pin_rggb_b", exp_pix(2, 2, 2, 0, 0), 25);
        cmp("pin_bggr_r", exp_pix(2, 2, 0, 3, 0), 25);
        cmp("pin_bggr_b", exp_pix(2, 2, 2, 3, 0), 250);
        run_frame(0, 0, -1, -1);
        run_frame(3, 0, -1, -1);

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                fr[y][x] = (x < 8) ? 10'd0 : 10'd1023;
        cmp("pin_edge_ed_g", exp_pix(2, 8, 1, 0, 1), 0);
        cmp("pin_edge_bl_g", exp_pix(2, 8, 1, 0, 0), 64);
        cmp("pin_edge_bl_r", exp_pix(1, 8, 0, 0, 0), 128);
        run_frame(0, 1, -1, -1);
        run_frame(0, 0, -1, -1);

        fill_rgb(800, 200, 100);
        cmp("pin_border_g", exp_pix(3, 1, 1, 0, 0), 50);
        cmp("pin_border_r", exp_pix(3, 1, 0, 0, 0), 200);
        run_frame(0, 0, -1, -1);

        fill_rand();
        run_frame(2, 1, 3, -1);
        fill_rand();
        run_frame(1, 0, -1, 4);
        lat_arm = 1;
        fill_rand();
        run_frame(1, 1, -1, -1);
        lat_arm = 0;
        for (int k = 0; k < 4; k++) begin
            fill_rand();
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, -1);
        end
        repeat (6) step(0, 0, 0, 0);

        cmp("sync_latency", lat_out - lat_in, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
